muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting beside the ALU in the execute stage: consumes decoded `funct3` and the two register operands from decode/register-file read, and produces the 32-bit result for the write-back result mux. Radix-2 shift-add and restoring-division datapath, one bit per cycle. Valid/ready handshakes on both sides let the core stall while the operation is in flight.

## Interface
- `DATA_WIDTH`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  unit can accept a request (high only in IDLE and `rst` high).
- `i_funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_rs1`  in  32  operand a (dividend / multiplicand).
- `i_rs2`  in  32  operand b (divisor / multiplier).
- `i_flush`  in  1  synchronous abort of any in-flight or pending operation.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_result`  out  32  result.
- `o_busy`  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: accept when `i_valid & o_ready` at an edge; latch op, operand magnitudes and result signs; go to CALC with 5-bit counter = 0, or directly to DONE on a fast-path case.
- Sign rules: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned. Magnitudes taken before iteration; negate the 64-bit product when sign(a)^sign(b) for signed operands. Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- CALC: one iteration per edge, counter increments, leave to DONE when counter == 31 at the edge (32 iterations). Multiply: 64-bit accumulator, add shifted multiplicand when multiplier LSB set. Divide: restoring, 33-bit partial remainder compare/subtract.
- Fast path (no CALC): divisor == 0 → DIV/DIVU = 0xFFFFFFFF, REM/REMU = `i_rs1`. Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF) → DIV = 0x80000000, REM = 0.
- DONE: `o_valid` high, `o_result` stable; on edge with `i_ready` high → IDLE. No new request accepted in the same edge.
- `i_flush` high at an edge in any state → IDLE, `o_valid` low next cycle, result discarded; flush wins over accept and over `i_ready`.
- `i_funct3` and operands are sampled only at the accept edge; changes afterwards have no effect.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, counter 0, accumulators 0, `o_valid` 0, `o_result` 0, `o_busy` 0, `o_ready` 0 while `rst` low, 1 in first cycle after release.
- Reset mid-operation: immediate abort, identical to power-on reset values.
- Normal latency: accept at edge E0; iterations at E1..E32; `o_valid` high in cycle after E32 (33 edges from accept).
- Fast-path latency: `o_valid` high in cycle after E0.
- Throughput: minimum one op per 34 cycles (normal), 2 cycles (fast path), plus consumer stall.
- `o_result` holds its value while `o_valid` high and `i_ready` low, for any number of cycles.
- `o_ready` is a function of state and `rst` only; no combinational path from `i_valid` or `i_ready`.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → `o_result` 0xFFFFFFEB, `o_valid` exactly 33 edges after accept; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REM 0xFFFFFFF9/0 → 0xFFFFFFF9, both `o_valid` one cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, fast path.
- Backpressure: hold `i_ready` low 10 cycles in DONE → `o_valid` and `o_result` stable, `o_ready` low, `i_valid` ignored; release → IDLE next edge, `o_ready` high.
- Flush at iteration 15 of a DIVU → IDLE next edge, no `o_valid` pulse; next MUL 3×4 → 12 correct.
- Assert `rst` low mid-CALC → all outputs at reset values immediately; after release, MULHU 0x10000×0x10000 → 1.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with
// valid/ready handshakes on request and result sides.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// CALC  | 32 iterations of the shift-add / restoring-divide loop
// DONE  | result held on o_result with o_valid high until consumed
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0]     cnt_q;
  logic [2:0]     op_q;
  logic           neg_q;      // negate product / quotient
  logic           neg_rem_q;  // negate remainder (sign of dividend)
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   divisor_q;
  logic [W-1:0]   result_q;

  // ---------------------------------------------------------------------
  // Request decode: operand signedness, magnitudes and fast-path detection
  // ---------------------------------------------------------------------
  logic           in_is_div;
  logic           in_is_rem;
  logic           in_sa;
  logic           in_sb;
  logic [W-1:0]   in_mag_a;
  logic [W-1:0]   in_mag_b;
  logic           in_div_zero;
  logic           in_ovf;
  logic           in_fast;
  logic [W-1:0]   in_fast_res;
  logic           accept;
  logic           last_iter;

  // Decode the incoming request into signs, magnitudes and fast-path result
  always_comb begin
    in_is_div   = i_funct3[2];
    in_is_rem   = i_funct3[1];
    if (in_is_div) begin
      in_sa = ~i_funct3[0] & i_rs1[W-1];
      in_sb = ~i_funct3[0] & i_rs2[W-1];
    end else begin
      in_sa = (i_funct3[1:0] != 2'b11) & i_rs1[W-1];
      in_sb = ~i_funct3[1] & i_rs2[W-1];
    end
    in_mag_a    = in_sa ? -i_rs1 : i_rs1;
    in_mag_b    = in_sb ? -i_rs2 : i_rs2;
    in_div_zero = (i_rs2 == '0);
    // Only the signed ops can overflow: most-negative / -1
    in_ovf      = ~i_funct3[0] &
                  (i_rs1 == {1'b1, {(W-1){1'b0}}}) &
                  (i_rs2 == {W{1'b1}});
    in_fast     = in_is_div & (in_div_zero | in_ovf);
    if (in_div_zero) begin
      in_fast_res = in_is_rem ? i_rs1 : {W{1'b1}};
    end else begin
      in_fast_res = in_is_rem ? '0 : {1'b1, {(W-1){1'b0}}};
    end
  end

  // Accept needs IDLE and no flush; reset is covered by the async register
  assign accept    = (state_q == S_IDLE) & i_valid & ~i_flush;
  assign last_iter = (cnt_q == 5'(W - 1));

  // ---------------------------------------------------------------------
  // Iteration datapath (combinational next values)
  // ---------------------------------------------------------------------
  logic [2*W-1:0] acc_nxt;
  logic [W:0]     trial;
  logic [W:0]     trial_sub;
  logic           trial_ge;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   quo_nxt;
  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo_signed;
  logic [W-1:0]   rem_signed;
  logic [W-1:0]   final_res;

  // One shift-add step and one restoring-divide step, plus final sign fixup
  always_comb begin
    acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // trial < 2*divisor, so the subtract's top bit is a clean borrow flag
    trial     = {rem_q, quo_q[W-1]};
    trial_sub = trial - {1'b0, divisor_q};
    trial_ge  = ~trial_sub[W];
    rem_nxt   = trial_ge ? trial_sub[W-1:0] : trial[W-1:0];
    quo_nxt   = {quo_q[W-2:0], trial_ge};

    prod_signed = neg_q ? -acc_nxt : acc_nxt;
    quo_signed  = neg_q ? -quo_nxt : quo_nxt;
    rem_signed  = neg_rem_q ? -rem_nxt : rem_nxt;

    if (op_q[2]) begin
      final_res = op_q[1] ? rem_signed : quo_signed;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod_signed[W-1:0] : prod_signed[2*W-1:W];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides accept and result consumption
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = in_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_flush || i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs, decoded from state (and reset for o_ready)
  always_comb begin
    o_ready = (state_q == S_IDLE) & rst;
    o_valid = (state_q == S_DONE);
    o_busy  = (state_q == S_CALC) | (state_q == S_DONE);
  end

  assign o_result = result_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // Load operands on accept, iterate in CALC, capture result on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= i_funct3;
      neg_q     <= in_sa ^ in_sb;
      neg_rem_q <= in_sa;
      acc_q     <= '0;
      mcand_q   <= {{W{1'b0}}, in_mag_a};
      mplier_q  <= in_mag_b;
      rem_q     <= '0;
      quo_q     <= in_mag_a;
      divisor_q <= in_mag_b;
      if (in_fast) begin
        result_q <= in_fast_res;
      end
    end else if ((state_q == S_CALC) && !i_flush) begin
      cnt_q <= cnt_q + 5'd1;
      if (op_q[2]) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end else begin
        acc_q    <= acc_nxt;
        mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[W-1:1]};
      end
      if (last_iter) begin
        result_q <= final_res;
      end
    end
  end

endmodule
